// File: rtl/seq_mult_bcd_pkg.sv
// Shared types, constants and sizing helpers for the sequential multiply-to-BCD block.
package seq_mult_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int BCD_W = 4;

   // Signed magnitudes top out at 2^(2N-2), so one bit fewer than unsigned is enough.
   function automatic int prod_width(input int n, input int signed_op);
      if (signed_op != 32'sd0) begin
         return (32'sd2 * n) - 32'sd1;
      end else begin
         return 32'sd2 * n;
      end
   endfunction

   function automatic int min_digits(input int n, input int signed_op);
      longint unsigned max_v;
      int              d;
      if (signed_op != 32'sd0) begin
         max_v = 64'd1 << ((32'sd2 * n) - 32'sd2);
      end else begin
         max_v = ((64'd1 << n) - 64'd1) * ((64'd1 << n) - 64'd1);
      end
      d = 32'sd0;
      while (max_v != 64'd0) begin
         d     = d + 32'sd1;
         max_v = max_v / 64'd10;
      end
      return d;
   endfunction

endpackage

// File: rtl/seq_mult_bcd_if.sv
// Request/result bundle between a requester and seq_mult_bcd.
interface seq_mult_bcd_if
   import seq_mult_bcd_pkg::*;
#(
   parameter int N      = 8,
   parameter int DIGITS = 5
) ();

   logic                      start;
   logic [N-1:0]              multiplier;
   logic [N-1:0]              multiplicand;
   logic                      busy;
   logic                      done;
   logic                      sign;
   logic                      zflag;
   logic [BCD_W*DIGITS-1:0]   bcd;

   modport master (
      output start, multiplier, multiplicand,
      input  busy, done, sign, zflag, bcd
   );

   modport slave (
      input  start, multiplier, multiplicand,
      output busy, done, sign, zflag, bcd
   );

endinterface

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble converter: load a P-bit value, then P step pulses leave its BCD digits on bcd.
module seq_bin2bcd
   import seq_mult_bcd_pkg::*;
#(
   parameter int P      = 15,
   parameter int DIGITS = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [P-1:0]            bin,
   input  logic                    step,
   output logic [BCD_W*DIGITS-1:0] bcd
);

   localparam int BW = BCD_W * DIGITS;

   logic [P-1:0]  bin_r;
   logic [BW-1:0] bcd_r;
   logic [BW-1:0] adj_s;

   // Add-3 correction on every digit that would overflow past 9 after the next doubling.
   always_comb begin
      adj_s = bcd_r;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_r[i*BCD_W +: BCD_W] >= 4'd5) begin
            adj_s[i*BCD_W +: BCD_W] = bcd_r[i*BCD_W +: BCD_W] + 4'd3;
         end else begin
            adj_s[i*BCD_W +: BCD_W] = bcd_r[i*BCD_W +: BCD_W];
         end
      end
   end

   // Shift register: binary bits enter the BCD field MSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_r <= '0;
         bcd_r <= '0;
      end else if (load) begin
         bin_r <= bin;
         bcd_r <= '0;
      end else if (step) begin
         {bcd_r, bin_r} <= {adj_s[BW-2:0], bin_r, 1'b0};
      end
   end

   assign bcd = bcd_r;

endmodule

// File: rtl/seq_mult_bcd.sv
// Sequential shift-add multiplier whose magnitude is converted to packed BCD, with sign and zero flags.
module seq_mult_bcd
   import seq_mult_bcd_pkg::*;
#(
   parameter int N      = 8,
   parameter int SIGNED = 1,
   parameter int DIGITS = 5
) (
   input  logic          clock,
   input  logic          reset_n,
   seq_mult_bcd_if.slave bus
);

   localparam int            P         = prod_width(N, SIGNED);
   localparam int            BW        = BCD_W * DIGITS;
   localparam int            CW        = $clog2(P + 1);
   localparam bit            IS_SIGNED = (SIGNED != 0);
   localparam logic [N-1:0]  ONE_N     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] MULT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CONV_LAST = CW'(P - 1);

   if (N < 2) begin : g_n_check
      $error("seq_mult_bcd: N must be at least 2");
   end
   if (DIGITS < min_digits(N, SIGNED)) begin : g_digits_check
      $error("seq_mult_bcd: DIGITS too small for the largest product magnitude");
   end

   state_e        state_r, state_s;
   logic [CW-1:0] cnt_r;
   logic [N-1:0]  mplier_r;
   logic [P-1:0]  mcand_r;
   logic [P-1:0]  acc_r;
   logic          neg_r;
   logic [N-1:0]  abs_a_s, abs_b_s;
   logic          neg_s;
   logic [P-1:0]  acc_add_s;
   logic          accept_s, mult_step_s, conv_load_s, conv_step_s, finish_s;
   logic [BW-1:0] conv_bcd_s;
   logic          busy_r, done_r, sign_r, zflag_r;
   logic [BW-1:0] bcd_r;

   // Operand magnitudes and product sign as seen at the accepting edge.
   always_comb begin
      abs_a_s = bus.multiplier;
      abs_b_s = bus.multiplicand;
      neg_s   = 1'b0;
      if (IS_SIGNED) begin
         if (bus.multiplier[N-1]) begin
            abs_a_s = ~bus.multiplier + ONE_N;
         end else begin
            abs_a_s = bus.multiplier;
         end
         if (bus.multiplicand[N-1]) begin
            abs_b_s = ~bus.multiplicand + ONE_N;
         end else begin
            abs_b_s = bus.multiplicand;
         end
         neg_s = bus.multiplier[N-1] ^ bus.multiplicand[N-1];
      end else begin
         neg_s = 1'b0;
      end
   end

   assign acc_add_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and per-phase strobes; DONE lasts one cycle so results land after edge N+P+1.
   always_comb begin
      state_s     = state_r;
      accept_s    = 1'b0;
      mult_step_s = 1'b0;
      conv_load_s = 1'b0;
      conv_step_s = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               accept_s = 1'b1;
               state_s  = MULT;
            end else begin
               state_s  = IDLE;
            end
         end
         MULT: begin
            mult_step_s = 1'b1;
            if (cnt_r == MULT_LAST) begin
               conv_load_s = 1'b1;
               state_s     = CONV;
            end else begin
               state_s     = MULT;
            end
         end
         CONV: begin
            conv_step_s = 1'b1;
            if (cnt_r == CONV_LAST) begin
               state_s = DONE;
            end else begin
               state_s = CONV;
            end
         end
         DONE: begin
            finish_s = 1'b1;
            state_s  = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Operand shifters, accumulator and phase counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r    <= '0;
         mplier_r <= '0;
         mcand_r  <= '0;
         acc_r    <= '0;
         neg_r    <= 1'b0;
      end else if (accept_s) begin
         cnt_r    <= '0;
         mplier_r <= abs_a_s;
         mcand_r  <= {{(P-N){1'b0}}, abs_b_s};
         acc_r    <= '0;
         neg_r    <= neg_s;
      end else if (mult_step_s) begin
         cnt_r    <= conv_load_s ? '0 : (cnt_r + CNT_ONE);
         acc_r    <= acc_add_s;
         mplier_r <= mplier_r >> 1'b1;
         mcand_r  <= mcand_r << 1'b1;
      end else if (conv_step_s) begin
         cnt_r    <= cnt_r + CNT_ONE;
      end
   end

   // The last multiply step feeds the converter directly so no cycle is spent reloading.
   seq_bin2bcd #(
      .P      (P),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk   (clock),
      .rst_n (reset_n),
      .load  (conv_load_s),
      .bin   (acc_add_s),
      .step  (conv_step_s),
      .bcd   (conv_bcd_s)
   );

   // Result registers hold their value until the next completion.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         sign_r  <= 1'b0;
         zflag_r <= 1'b0;
         bcd_r   <= '0;
      end else begin
         done_r <= finish_s;
         if (accept_s) begin
            busy_r <= 1'b1;
         end else if (finish_s) begin
            busy_r  <= 1'b0;
            bcd_r   <= conv_bcd_s;
            zflag_r <= (acc_r == '0);
            sign_r  <= neg_r & (acc_r != '0);
         end
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.sign  = sign_r;
   assign bus.zflag = zflag_r;
   assign bus.bcd   = bcd_r;

endmodule

// File: tb/tb_seq_mult_bcd.sv
// Self-checking bench: signed and unsigned N=8 instances against an integer-arithmetic reference.
module tb_seq_mult_bcd;
   import seq_mult_bcd_pkg::*;

   localparam int N      = 8;
   localparam int DIGITS = 5;
   localparam int BW     = BCD_W * DIGITS;
   localparam int LAT_S  = 3 * N;
   localparam int LAT_U  = 3 * N + 1;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;

   seq_mult_bcd_if #(.N(N), .DIGITS(DIGITS)) sbus ();
   seq_mult_bcd_if #(.N(N), .DIGITS(DIGITS)) ubus ();

   seq_mult_bcd #(.N(N), .SIGNED(1), .DIGITS(DIGITS)) dut_s (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (sbus.slave)
   );

   seq_mult_bcd #(.N(N), .SIGNED(0), .DIGITS(DIGITS)) dut_u (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ubus.slave)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit uns, input logic st, input logic [N-1:0] a, input logic [N-1:0] b);
      if (uns) begin
         ubus.start = st; ubus.multiplier = a; ubus.multiplicand = b;
      end else begin
         sbus.start = st; sbus.multiplier = a; sbus.multiplicand = b;
      end
   endtask

   task automatic sample(input bit uns, output logic ob, output logic od, output logic os,
                         output logic oz, output logic [BW-1:0] oq);
      if (uns) begin
         ob = ubus.busy; od = ubus.done; os = ubus.sign; oz = ubus.zflag; oq = ubus.bcd;
      end else begin
         ob = sbus.busy; od = sbus.done; os = sbus.sign; oz = sbus.zflag; oq = sbus.bcd;
      end
   endtask

   // Reference: full-precision integer product, decimal digits by repeated division.
   task automatic model(input bit uns, input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic es, output logic ez, output logic [BW-1:0] eq);
      longint pa, pb, p;
      longint unsigned mag;
      if (uns) begin
         pa = longint'(a); pb = longint'(b);
      end else begin
         pa = longint'($signed(a)); pb = longint'($signed(b));
      end
      p   = pa * pb;
      es  = (p < 0);
      ez  = (p == 0);
      mag = (p < 0) ? longint'(-p) : longint'(p);
      eq  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         eq[i*BCD_W +: BCD_W] = 4'(mag % 64'd10);
         mag = mag / 64'd10;
      end
   endtask

   // Drive start for one edge, then scramble the operand inputs.
   task automatic launch(input bit uns, input logic [N-1:0] a, input logic [N-1:0] b);
      drive(uns, 1'b1, a, b);
      tick();
      drive(uns, 1'b0, N'($urandom), N'($urandom));
   endtask

   task automatic wait_done(input bit uns, output int cyc);
      logic ob, od, os, oz;
      logic [BW-1:0] oq;
      cyc = -1;
      for (int c = 1; c <= 80; c++) begin
         tick();
         sample(uns, ob, od, os, oz, oq);
         if (od === 1'b1) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic run_and_check(input string name, input bit uns, input logic [N-1:0] a, input logic [N-1:0] b);
      logic es, ez, ob, od, os, oz;
      logic [BW-1:0] eq, oq;
      int cyc, lat;
      model(uns, a, b, es, ez, eq);
      lat = uns ? LAT_U : LAT_S;
      launch(uns, a, b);
      sample(uns, ob, od, os, oz, oq);
      tests_run++;
      if (ob !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s busy_after_start: got %b want 1", name, ob);
      end
      wait_done(uns, cyc);
      tests_run++;
      if (cyc != lat) begin
         tests_failed++;
         $display("FAIL %s latency: got %0d want %0d (a=%h b=%h)", name, cyc, lat, a, b);
      end
      sample(uns, ob, od, os, oz, oq);
      tests_run++;
      if ({os, oz, oq, ob} !== {es, ez, eq, 1'b0}) begin
         tests_failed++;
         $display("FAIL %s result: got sign=%b z=%b bcd=%h busy=%b want sign=%b z=%b bcd=%h busy=0 (a=%h b=%h)",
                  name, os, oz, oq, ob, es, ez, eq, a, b);
      end
      tick();
      sample(uns, ob, od, os, oz, oq);
      tests_run++;
      if (od !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s done_pulse_width: got done=%b want 0", name, od);
      end
   endtask

   task automatic test_reset();
      logic ob, od, os, oz;
      logic [BW-1:0] oq;
      reset_n = 1'b0;
      drive(1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, '0, '0);
      repeat (3) tick();
      for (int u = 0; u < 2; u++) begin
         sample(u[0], ob, od, os, oz, oq);
         tests_run++;
         if ({ob, od, os, oz, oq} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state[%0d]: got busy=%b done=%b sign=%b z=%b bcd=%h want all 0",
                     u, ob, od, os, oz, oq);
         end
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      run_and_check("s_12x-7",      1'b0, 8'd12,  8'hF9);
      run_and_check("s_-128x-128",  1'b0, 8'h80,  8'h80);
      run_and_check("s_0x-5",       1'b0, 8'd0,   8'hFB);
      run_and_check("s_127x-128",   1'b0, 8'h7F,  8'h80);
      run_and_check("u_255x255",    1'b1, 8'hFF,  8'hFF);
      run_and_check("u_0x0",        1'b1, 8'd0,   8'd0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         run_and_check("rand_s", 1'b0, N'($urandom), N'($urandom));
         run_and_check("rand_u", 1'b1, N'($urandom), N'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      logic es, ez, ob, od, os, oz;
      logic [BW-1:0] eq, oq;
      int done_cnt, first, cyc;
      launch(1'b0, 8'd3, 8'd5);
      done_cnt = 0;
      first    = -1;
      for (int c = 1; c <= LAT_S; c++) begin
         if (c == 10) drive(1'b0, 1'b1, 8'd9, 8'd9);
         tick();
         if (c == 10) drive(1'b0, 1'b0, 8'd0, 8'd0);
         sample(1'b0, ob, od, os, oz, oq);
         if (od === 1'b1) begin
            done_cnt++;
            if (first < 0) first = c;
         end
      end
      model(1'b0, 8'd3, 8'd5, es, ez, eq);
      tests_run++;
      if (done_cnt != 1 || first != LAT_S || oq !== eq || os !== es) begin
         tests_failed++;
         $display("FAIL busy_ignore: got dones=%0d first=%0d bcd=%h want dones=1 first=%0d bcd=%h",
                  done_cnt, first, oq, LAT_S, eq);
      end
      // Still in the done cycle: a start here must be taken.
      launch(1'b0, 8'd9, 8'd9);
      sample(1'b0, ob, od, os, oz, oq);
      tests_run++;
      if (ob !== 1'b1 || od !== 1'b0 || oq !== eq) begin
         tests_failed++;
         $display("FAIL b2b_accept_hold: got busy=%b done=%b bcd=%h want busy=1 done=0 bcd=%h", ob, od, oq, eq);
      end
      wait_done(1'b0, cyc);
      sample(1'b0, ob, od, os, oz, oq);
      model(1'b0, 8'd9, 8'd9, es, ez, eq);
      tests_run++;
      if (cyc != LAT_S || oq !== eq || oz !== ez || os !== es) begin
         tests_failed++;
         $display("FAIL b2b_result: got cyc=%0d bcd=%h want cyc=%0d bcd=%h", cyc, oq, LAT_S, eq);
      end
      tick();
   endtask

   task automatic test_reset_abort();
      logic ob, od, os, oz;
      logic [BW-1:0] oq;
      int seen;
      launch(1'b0, 8'd50, 8'hFD);
      repeat (6) tick();
      reset_n = 1'b0;
      #1;
      sample(1'b0, ob, od, os, oz, oq);
      tests_run++;
      if ({ob, od, os, oz, oq} !== '0) begin
         tests_failed++;
         $display("FAIL abort_clear: got busy=%b done=%b sign=%b z=%b bcd=%h want all 0", ob, od, os, oz, oq);
      end
      seen = 0;
      repeat (3) begin
         tick();
         sample(1'b0, ob, od, os, oz, oq);
         if (od === 1'b1) seen++;
      end
      reset_n = 1'b1;
      repeat (30) begin
         tick();
         sample(1'b0, ob, od, os, oz, oq);
         if (od === 1'b1 || ob === 1'b1) seen++;
      end
      tests_run++;
      if (seen != 0) begin
         tests_failed++;
         $display("FAIL abort_no_done: got %0d busy/done cycles want 0", seen);
      end
      run_and_check("s_4x4_after_abort", 1'b0, 8'd4, 8'd4);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
